// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// -----------------------------------------------------------------------------
// This block drives and samples a gate-level 2-to-1 mux stage. It sets the mux
// select, waits DWELL cycles, samples the mux output into a result register,
// then toggles the select. It takes 2*NPAIR samples per run, starting with s=0.
//
// Compile-time option: MUX_SEQ_CHECK_EN. When it is defined, every sample is
// compared against (s ? y_obs : x_obs). Any mismatch sets the sticky `error`
// flag. When it is undefined, `error` is tied to 0 and x_obs/y_obs are unused.
//
// Parameters:
//   DWELL  cycles each select value is held before m is sampled (>=1)
//   NPAIR  number of (s=0, s=1) sample pairs per run (>=1)
//
// Ports:
//   clock    in   system clock; all logic is on the rising edge
//   reset    in   synchronous, active-high reset; it aborts a run
//   start    in   run request; it is only sampled in IDLE
//   x_obs    in   copy of mux input x (used by the optional check)
//   y_obs    in   copy of mux input y (used by the optional check)
//   m        in   mux output being sampled
//   s        out  select driven to the mux
//   busy     out  high while the run is sampling
//   done     out  one-cycle pulse at the end of a run
//   samples  out  captured m values; bit 2i is taken with s=0, bit 2i+1 with s=1
//   error    out  sticky mismatch flag
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
  parameter int DWELL = 2,
  parameter int NPAIR = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               x_obs,
  input  logic               y_obs,
  input  logic               m,
  output logic               s,
  output logic               busy,
  output logic               done,
  output logic [2*NPAIR-1:0] samples,
  output logic               error
);

  localparam int NSAMP = 2 * NPAIR;
  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam int IDX_W = $clog2(NSAMP) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               s_q, s_d;
  logic [NSAMP-1:0]   samples_q, samples_d;

`ifdef MUX_SEQ_CHECK_EN
  logic               error_q, error_d;
`else
  // The observation inputs only feed the optional check.
  logic               unused_obs;
  assign unused_obs = x_obs ^ y_obs;
`endif

  // NOTE: every variable gets its hold value before the case statement.
  // This keeps each path fully assigned, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    s_d       = s_q;
    samples_d = samples_q;
`ifdef MUX_SEQ_CHECK_EN
    error_d   = error_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          samples_d = '0;
          cnt_d     = '0;
          idx_d     = '0;
          s_d       = 1'b0;
`ifdef MUX_SEQ_CHECK_EN
          error_d   = 1'b0;
`endif
          state_d   = SETTLE;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          // Sample edge: capture m into the slot for the current index.
          for (int i = 0; i < NSAMP; i++) begin
            if (idx_q == IDX_W'(i)) samples_d[i] = m;
          end
`ifdef MUX_SEQ_CHECK_EN
          // Compare against the input that the pre-toggle select routes out.
          if (m != (s_q ? y_obs : x_obs)) error_d = 1'b1;
`endif
          cnt_d = '0;
          s_d   = ~s_q;
          if (idx_q == IDX_W'(NSAMP - 1)) begin
            s_d     = 1'b0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together from the values they held before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      s_q       <= 1'b0;
      samples_q <= '0;
`ifdef MUX_SEQ_CHECK_EN
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      s_q       <= s_d;
      samples_q <= samples_d;
`ifdef MUX_SEQ_CHECK_EN
      error_q   <= error_d;
`endif
    end
  end

  assign s       = s_q;
  assign busy    = (state_q == SETTLE);
  assign done    = (state_q == DONE);
  assign samples = samples_q;
`ifdef MUX_SEQ_CHECK_EN
  assign error   = error_q;
`else
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer
// Directed bench for mux_sel_sequencer. Instance u_a uses DWELL=2, NPAIR=4.
// Instance u_b uses DWELL=1, NPAIR=1. Each instance drives a behavioural
// 2-to-1 mux model.
module tb_mux_sel_sequencer;

  localparam int DW = 2;
  localparam int NP = 4;
  localparam int RUN_CYC = 2 * NP * DW;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic       x_a, y_a, stuck_a;
  logic       x_b, y_b;
  logic       m_a, m_b;
  logic       s_a, busy_a, done_a, err_a;
  logic       s_b, busy_b, done_b, err_b;
  logic [7:0] samp_a;
  logic [1:0] samp_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Mux models. stuck_a forces the u_a mux output to 0.
  assign m_a = stuck_a ? 1'b0 : (s_a ? y_a : x_a);
  assign m_b = s_b ? y_b : x_b;

  mux_sel_sequencer #(.DWELL(DW), .NPAIR(NP)) u_a (
    .clock(clock), .reset(reset), .start(start_a),
    .x_obs(x_a), .y_obs(y_a), .m(m_a),
    .s(s_a), .busy(busy_a), .done(done_a), .samples(samp_a), .error(err_a)
  );

  mux_sel_sequencer #(.DWELL(1), .NPAIR(1)) u_b (
    .clock(clock), .reset(reset), .start(start_b),
    .x_obs(x_b), .y_obs(y_b), .m(m_b),
    .s(s_b), .busy(busy_b), .done(done_b), .samples(samp_b), .error(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Moves to 1 time unit after the next rising edge, away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one complete u_a run and checks it every cycle. If poke > 0, start is
  // pulsed again after cycle `poke`; that pulse must have no effect.
  task automatic run_a(input logic [7:0] exp_samp, input int poke);
    start_a = 1'b1;
    tick();                               // accepting edge
    start_a = 1'b0;
    check("acc_busy", 32'(busy_a), 32'd1);
    check("acc_s", 32'(s_a), 32'd0);
    check("acc_samples_cleared", 32'(samp_a), 32'd0);
    for (int k = 1; k <= RUN_CYC; k++) begin
      tick();
      start_a = 1'b0;
      check("run_s", 32'(s_a), (k < RUN_CYC) ? 32'((k / DW) % 2) : 32'd0);
      check("run_busy", 32'(busy_a), (k < RUN_CYC) ? 32'd1 : 32'd0);
      check("run_done", 32'(done_a), (k == RUN_CYC) ? 32'd1 : 32'd0);
      if (k == poke) start_a = 1'b1;
    end
    check("run_samples", 32'(samp_a), 32'(exp_samp));
    check("run_error", 32'(err_a), 32'd0);
    tick();
    check("post_done", 32'(done_a), 32'd0);
    check("post_busy", 32'(busy_a), 32'd0);
    check("post_samples_hold", 32'(samp_a), 32'(exp_samp));
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    x_a = 1'b0; y_a = 1'b1; stuck_a = 1'b0;
    x_b = 1'b0; y_b = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_s", 32'(s_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_samples", 32'(samp_a), 32'd0);
    check("rst_error", 32'(err_a), 32'd0);
    tick();
    check("idle_busy", 32'(busy_a), 32'd0);

    // Nominal run with x=0, y=1. Only the s=1 samples read 1.
    run_a(8'b1010_1010, 0);

    // x=1, y=0 inverts the pattern. A start pulse mid-run must be ignored.
    x_a = 1'b1; y_a = 1'b0;
    run_a(8'b0101_0101, 5);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("no_queued_start", 32'(busy_a), 32'd0);
    end

    // x=y=1: all ones. run_a also confirms the old 0x55 is cleared at accept.
    x_a = 1'b1; y_a = 1'b1;
    run_a(8'hFF, 0);

    // Reset at cycle 7 of a run aborts it. Bits already captured must clear.
    x_a = 1'b0; y_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    check("pre_abort_samples", 32'(samp_a), 32'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_s", 32'(s_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_samples", 32'(samp_a), 32'd0);
    for (int k = 0; k < RUN_CYC + 4; k++) begin
      tick();
      check("abort_no_done", 32'(done_a), 32'd0);
    end
    run_a(8'b1010_1010, 0);

    // Start held high: after done there is one IDLE cycle, then a new run.
    start_a = 1'b1;
    for (int k = 0; k <= RUN_CYC; k++) tick();
    check("held_done", 32'(done_a), 32'd1);
    tick();
    check("held_idle_gap", 32'(busy_a), 32'd0);
    tick();
    check("held_restart", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // u_b with DWELL=1, NPAIR=1: s toggles every edge, and done follows 2 edges.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("d1_acc_s", 32'(s_b), 32'd0);
    check("d1_acc_busy", 32'(busy_b), 32'd1);
    tick();
    check("d1_s_toggle", 32'(s_b), 32'd1);
    check("d1_busy", 32'(busy_b), 32'd1);
    check("d1_no_done_yet", 32'(done_b), 32'd0);
    tick();
    check("d1_done", 32'(done_b), 32'd1);
    check("d1_s_final", 32'(s_b), 32'd0);
    check("d1_samples", 32'(samp_b), 32'b10);
    check("d1_error", 32'(err_b), 32'd0);

`ifdef MUX_SEQ_CHECK_EN
    // Mux stuck at 0 with x=0, y=1: error rises at the first s=1 sample edge.
    x_a = 1'b0; y_a = 1'b1; stuck_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= RUN_CYC; k++) begin
      tick();
      check("chk_error", 32'(err_a), (k >= 2 * DW) ? 32'd1 : 32'd0);
    end
    check("chk_samples", 32'(samp_a), 32'h00);
    tick();
    check("chk_error_sticky", 32'(err_a), 32'd1);
    stuck_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("chk_error_cleared", 32'(err_a), 32'd0);
    for (int k = 1; k <= RUN_CYC; k++) tick();
    check("chk_good_samples", 32'(samp_a), 32'hAA);
    check("chk_good_error", 32'(err_a), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
